valid_pattern_generator: RTL and testbench

- TX-side VALTRAIN source for the mainband valid lane; the direct upstream stage of the RX valid pattern detector.
- Emits 32-bit words of the VALTRAIN pattern (8'b11110000 repeated four times, 0xF0F0F0F0) toward the valid-lane serializer under a ready/valid handshake.
- Supports a fixed-length burst of 128 iterations (ITER_128) and a free-running mode (CONSEC) that runs until a stop request.
- The sideband training FSM starts and stops the block and observes completion.

---
 rtl/valid_pattern_generator.sv | 118 +++++++++++
 tb/tb_valid_pattern_generator.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/valid_pattern_generator.sv
// VALTRAIN source for the mainband valid lane: streams 0xF0F0F0F0 words to the
// serializer under ready/valid, as a fixed 128-iteration burst or a free-running stream.
module valid_pattern_generator #(
  parameter int ITER_TARGET    = 128,
  parameter int ITERS_PER_WORD = 4,
  parameter int CNT_W          = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic [1:0]       i_mode,
  input  logic             i_stop,
  input  logic             i_ser_ready,
  output logic [31:0]      o_tvld_l,
  output logic             o_word_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_iter_count
);

  localparam logic [1:0]       MODE_ITER = 2'b01;
  localparam logic [1:0]       MODE_FREE = 2'b10;
  localparam logic [CNT_W-1:0] STEP      = CNT_W'(ITERS_PER_WORD);
  localparam logic [CNT_W-1:0] TARGET    = CNT_W'(ITER_TARGET);
  localparam logic [CNT_W-1:0] SAT       = CNT_W'((1 << CNT_W) - ITERS_PER_WORD);

  typedef enum logic [1:0] {IDLE, SEND_ITER, SEND_FREE, DONE} state_t;

  state_t           state_reg, state_next;
  logic             stop_pend_reg, stop_pend_next;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] count_sat;
  logic             valid_next;
  logic             done_next;
  logic [31:0]      word_next;
  logic [31:0]      pattern;
  logic             accept;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pattern
      assign pattern[gi*8 +: 8] = 8'hF0;
    end
  endgenerate

  assign accept    = o_word_valid & i_ser_ready;
  assign count_inc = o_iter_count + STEP;
  // Free-running count sticks at the last representable multiple of STEP.
  assign count_sat = (o_iter_count >= SAT - STEP) ? SAT : count_inc;

  always_comb begin
    state_next     = state_reg;
    stop_pend_next = stop_pend_reg;
    count_next     = o_iter_count;
    case (state_reg)
      IDLE: begin
        count_next = '0;
        if (i_enable && i_mode == MODE_ITER)      state_next = SEND_ITER;
        else if (i_enable && i_mode == MODE_FREE) state_next = SEND_FREE;
      end
      SEND_ITER: begin
        if (!i_enable) begin
          state_next = IDLE;
          count_next = '0;
        end else if (accept) begin
          count_next = count_inc;
          if (count_inc == TARGET) state_next = DONE;
        end
      end
      SEND_FREE: begin
        if (!i_enable) begin
          state_next = IDLE;
          count_next = '0;
        end else if (accept) begin
          count_next = count_sat;
          if (i_stop || stop_pend_reg) state_next = DONE;
        end else if (i_stop) begin
          stop_pend_next = 1'b1;
        end
      end
      DONE: begin
        if (!i_enable) begin
          state_next = IDLE;
          count_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
    if (state_next != SEND_FREE) stop_pend_next = 1'b0;
    valid_next = (state_next == SEND_ITER) || (state_next == SEND_FREE);
    done_next  = (state_next == DONE);
    word_next  = valid_next ? pattern : 32'h0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= IDLE;
      stop_pend_reg <= 1'b0;
      o_tvld_l      <= 32'h0;
      o_word_valid  <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_iter_count  <= '0;
    end else begin
      state_reg     <= state_next;
      stop_pend_reg <= stop_pend_next;
      o_tvld_l      <= word_next;
      o_word_valid  <= valid_next;
      o_busy        <= valid_next;
      o_done        <= done_next;
      o_iter_count  <= count_next;
    end
  end

endmodule

// File: tb/tb_valid_pattern_generator.sv
// Randomized and directed bench for valid_pattern_generator against a word-counting
// reference model; one line per accepted word.
module tb_valid_pattern_generator;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_enable = 1'b0;
  logic [1:0]  i_mode = 2'b00;
  logic        i_stop = 1'b0;
  logic        i_ser_ready = 1'b0;
  logic [31:0] o_tvld_l;
  logic        o_word_valid;
  logic        o_busy;
  logic        o_done;
  logic [7:0]  o_iter_count;

  valid_pattern_generator dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_enable     (i_enable),
    .i_mode       (i_mode),
    .i_stop       (i_stop),
    .i_ser_ready  (i_ser_ready),
    .o_tvld_l     (o_tvld_l),
    .o_word_valid (o_word_valid),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_iter_count (o_iter_count)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a session is either inactive, streaming or finished;
  // the count is derived from the number of accepted words.
  bit m_active = 1'b0;
  bit m_free   = 1'b0;
  bit m_stop   = 1'b0;
  bit m_fin    = 1'b0;
  int m_words  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] exp_count();
    int c;
    c = m_words * 4;
    if (!m_active) return 32'd0;
    if (m_free && c > 252) return 32'd252;
    return 32'(c);
  endfunction

  task automatic check_outputs();
    bit v;
    v = m_active && !m_fin;
    check("word_valid", {31'b0, o_word_valid}, {31'b0, v});
    check("busy",       {31'b0, o_busy},       {31'b0, v});
    check("done",       {31'b0, o_done},       {31'b0, m_active && m_fin});
    check("tvld",       o_tvld_l,              v ? 32'hF0F0F0F0 : 32'h0);
    check("iter_count", {24'b0, o_iter_count}, exp_count());
  endtask

  task automatic cycle(input bit en, input logic [1:0] mode, input bit stop, input bit rdy);
    bit mv;
    i_enable    = en;
    i_mode      = mode;
    i_stop      = stop;
    i_ser_ready = rdy;
    mv = m_active && !m_fin;
    if (!m_active) begin
      if (en && (mode == 2'b01 || mode == 2'b10)) begin
        m_active = 1'b1;
        m_free   = (mode == 2'b10);
        m_words  = 0;
        m_stop   = 1'b0;
        m_fin    = 1'b0;
      end
    end else if (!en) begin
      m_active = 1'b0;
      m_words  = 0;
      m_stop   = 1'b0;
      m_fin    = 1'b0;
    end else if (mv) begin
      if (rdy) begin
        m_words++;
        $display("xfer %s word=%0d stop=%0b", m_free ? "free" : "iter", m_words, stop);
      end
      if (m_free) begin
        if (stop) m_stop = 1'b1;
        if (rdy && m_stop) m_fin = 1'b1;
      end else if (m_words * 4 >= 128) begin
        m_fin = 1'b1;
      end
    end
    @(posedge i_clk);
    #1;
    check_outputs();
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_free   = 1'b0;
    m_stop   = 1'b0;
    m_fin    = 1'b0;
    m_words  = 0;
  endtask

  initial begin
    bit rpat [4];
    rpat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state
    #3;
    check_outputs();
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    cycle(0, 2'b00, 0, 0);

    // ITER_128 with ready held high; a stray stop is ignored
    cycle(1, 2'b01, 0, 1);
    check("iter1_first_word", o_tvld_l, 32'hF0F0F0F0);
    for (int k = 0; k < 40 && !m_fin; k++) cycle(1, 2'b01, (k == 5), 1);
    check("iter1_done", {31'b0, o_done}, 32'd1);
    check("iter1_count", {24'b0, o_iter_count}, 32'd128);
    check("iter1_tvld", o_tvld_l, 32'h0);
    for (int k = 0; k < 10; k++) cycle(1, 2'b01, 0, 1);
    check("iter1_no_restart", {31'b0, o_word_valid}, 32'd0);
    cycle(0, 2'b01, 0, 1);
    check("iter1_rearm_clear", {24'b0, o_iter_count}, 32'd0);

    // ITER_128 with ready 1,0,0,1 and mode wiggled after start
    cycle(1, 2'b01, 0, 0);
    for (int k = 0; k < 200 && !m_fin; k++)
      cycle(1, 2'($urandom_range(0, 3)), 0, rpat[k % 4]);
    check("iter2_done", {31'b0, o_done}, 32'd1);
    check("iter2_count", {24'b0, o_iter_count}, 32'd128);
    cycle(0, 2'b00, 0, 0);

    // CONSEC: stop coincides with the 10th accept -> 40
    cycle(1, 2'b10, 0, 1);
    while (m_words < 9) cycle(1, 2'b10, 0, 1);
    cycle(1, 2'b10, 1, 1);
    check("free_stop40_done", {31'b0, o_done}, 32'd1);
    check("free_stop40_count", {24'b0, o_iter_count}, 32'd40);
    cycle(0, 2'b10, 0, 1);

    // CONSEC: stop while stalled after 10 words -> held, then 11th accept ends it
    cycle(1, 2'b10, 0, 1);
    while (m_words < 10) cycle(1, 2'b10, 0, 1);
    cycle(1, 2'b10, 1, 0);
    cycle(1, 2'b10, 0, 0);
    check("free_pend_valid", {31'b0, o_word_valid}, 32'd1);
    check("free_pend_tvld", o_tvld_l, 32'hF0F0F0F0);
    cycle(1, 2'b10, 0, 1);
    check("free_pend_done", {31'b0, o_done}, 32'd1);
    check("free_pend_count", {24'b0, o_iter_count}, 32'd44);
    cycle(0, 2'b10, 0, 0);

    // CONSEC saturation after 80 words
    cycle(1, 2'b10, 0, 1);
    while (m_words < 80) cycle(1, 2'b10, 0, 1);
    check("free_sat_count", {24'b0, o_iter_count}, 32'd252);
    check("free_sat_tvld", o_tvld_l, 32'hF0F0F0F0);
    cycle(1, 2'b10, 1, 1);
    check("free_sat_done_count", {24'b0, o_iter_count}, 32'd252);
    cycle(0, 2'b10, 0, 1);

    // Abort at word 15 of ITER_128
    cycle(1, 2'b01, 0, 1);
    while (m_words < 15) cycle(1, 2'b01, 0, 1);
    cycle(0, 2'b01, 0, 1);
    check("abort_valid", {31'b0, o_word_valid}, 32'd0);
    check("abort_done", {31'b0, o_done}, 32'd0);
    check("abort_count", {24'b0, o_iter_count}, 32'd0);

    // Invalid modes keep the block idle
    for (int k = 0; k < 5; k++) cycle(1, 2'b11, 0, 1);
    check("mode11_idle", {31'b0, o_busy}, 32'd0);
    cycle(0, 2'b11, 0, 1);
    for (int k = 0; k < 3; k++) cycle(1, 2'b00, 0, 1);
    check("mode00_idle", {31'b0, o_word_valid}, 32'd0);
    cycle(0, 2'b00, 0, 1);

    // Asynchronous reset mid-burst
    cycle(1, 2'b01, 0, 1);
    while (m_words < 10) cycle(1, 2'b01, 0, 1);
    i_rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_valid", {31'b0, o_word_valid}, 32'd0);
    check("rst_count", {24'b0, o_iter_count}, 32'd0);
    check("rst_tvld", o_tvld_l, 32'h0);
    check_outputs();
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    cycle(0, 2'b00, 0, 0);

    // Randomized traffic
    for (int k = 0; k < 1000; k++) begin
      bit en;
      logic [1:0] md;
      en = ($urandom_range(0, 24) != 0);
      md = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3))
                                       : (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
      cycle(en, md, ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
